cache_arbiter: RTL and testbench

Arbitrates a single physical-memory port between the instruction-side cache (port A) and the data-side cache (port B) of the pipelined LC-3b core. Sits between the two L1 caches and physical memory. Captures the winning request into holding registers, runs exactly one line transaction at a time, and routes the response back to the granted requester. Uses alternating priority on ties, so neither fetch nor data traffic can starve the other.

---
 rtl/lc3b_types.sv | 36 +++
 rtl/arbiter_hold_reg.sv | 34 +++
 rtl/cache_arbiter.sv | 122 ++++++++++++
 tb/tb_cache_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b type package.
//   LC3B_ADDR_W / LC3B_LINE_W : default byte-address and cache-line widths
//   lc3b_line                 : one cache line
//   arb_state_e               : cache_arbiter FSM states
//   lc3b_mem_op               : memory operation held for the granted request
//   b_op()                    : D-side command decode (read+write together counts as write)
package lc3b_types;

   localparam int LC3B_ADDR_W = 16;
   localparam int LC3B_LINE_W = 128;

   typedef logic [LC3B_LINE_W-1:0] lc3b_line;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_A = 2'd1,
      SERVE_B = 2'd2
   } arb_state_e;

   typedef enum logic [1:0] {
      NONE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } lc3b_mem_op;

   // An illegal read+write from the D-side resolves to a write so a dirty
   // line is never silently dropped.
   function automatic lc3b_mem_op b_op(input logic rd, input logic wr);
      if (wr)
         return WRITE;
      else if (rd)
         return READ;
      return NONE;
   endfunction

endpackage

// File: rtl/arbiter_hold_reg.sv
// Holding register for the granted memory request.
//   clk, rst_n : clock, async active-low clear (clears op/addr/wdata to 0)
//   load       : capture op_d/addr_d/wdata_d this edge
//   op_q/addr_q/wdata_q : held request, drives the physical memory port
module arbiter_hold_reg
   import lc3b_types::*;
#(
   parameter int ADDR_W = LC3B_ADDR_W,
   parameter int LINE_W = LC3B_LINE_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [1:0]        op_d,
   input  logic [ADDR_W-1:0] addr_d,
   input  logic [LINE_W-1:0] wdata_d,
   output logic [1:0]        op_q,
   output logic [ADDR_W-1:0] addr_q,
   output logic [LINE_W-1:0] wdata_q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= NONE;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (load) begin
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the I-cache (port A, read only)
// and the D-cache (port B, read/write). One line transaction at a time; the
// winner is captured into hold registers so the requester may change or drop
// its inputs mid-service. Ties alternate, starting with B after reset.
//   a_read/a_addr            : I-side request, a_resp/a_rdata completion
//   b_read/b_write/b_addr/b_wdata : D-side request, b_resp/b_rdata completion
//   pmem_read/pmem_write/pmem_addr/pmem_wdata : memory command (from hold regs)
//   pmem_resp/pmem_rdata     : memory completion, routed to the granted side
module cache_arbiter
   import lc3b_types::*;
#(
   parameter int ADDR_W = LC3B_ADDR_W,
   parameter int LINE_W = LC3B_LINE_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_read,
   input  logic [ADDR_W-1:0] a_addr,
   output logic              a_resp,
   output logic [LINE_W-1:0] a_rdata,
   input  logic              b_read,
   input  logic              b_write,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [LINE_W-1:0] b_wdata,
   output logic              b_resp,
   output logic [LINE_W-1:0] b_rdata,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_addr,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic              pmem_resp,
   input  logic [LINE_W-1:0] pmem_rdata
);

   arb_state_e        state, state_nx;
   logic              last_b;       // 1: most recent grant went to B
   logic              a_req, b_req;
   logic              grant_a, grant_b, load;
   logic              busy;
   logic [1:0]        ld_op, hold_op;
   logic [ADDR_W-1:0] ld_addr, hold_addr;
   logic [LINE_W-1:0] ld_wdata, hold_wdata;

   assign a_req = a_read;
   assign b_req = b_read | b_write;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         last_b <= 1'b0;
      end else begin
         state <= state_nx;
         if (load)
            last_b <= grant_b;
      end
   end

   // Grants only happen from IDLE, which also guarantees the one idle cycle
   // between transactions: a requester dropping after its resp is never
   // re-sampled while still high.
   always_comb begin
      state_nx = state;
      grant_a  = 1'b0;
      grant_b  = 1'b0;
      case (state)
         IDLE: begin
            if (a_req && b_req) begin
               grant_a = last_b;
               grant_b = !last_b;
            end else begin
               grant_a = a_req;
               grant_b = b_req;
            end
            if (grant_a)
               state_nx = SERVE_A;
            else if (grant_b)
               state_nx = SERVE_B;
         end
         SERVE_A, SERVE_B: begin
            if (pmem_resp)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign load     = grant_a | grant_b;
   assign ld_op    = grant_b ? b_op(b_read, b_write) : READ;
   assign ld_addr  = grant_b ? b_addr : a_addr;
   // Only a write carries data; reads hold zero so pmem_wdata stays quiet.
   assign ld_wdata = (grant_b && b_write) ? b_wdata : '0;

   arbiter_hold_reg #(
      .ADDR_W (ADDR_W),
      .LINE_W (LINE_W)
   ) u_hold (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .op_d    (ld_op),
      .addr_d  (ld_addr),
      .wdata_d (ld_wdata),
      .op_q    (hold_op),
      .addr_q  (hold_addr),
      .wdata_q (hold_wdata)
   );

   // Command comes only from registers, so it is glitch-free and stable
   // from the grant edge until the edge after pmem_resp.
   assign busy       = (state != IDLE);
   assign pmem_read  = busy && (hold_op == READ);
   assign pmem_write = busy && (hold_op == WRITE);
   assign pmem_addr  = busy ? hold_addr : '0;
   assign pmem_wdata = busy ? hold_wdata : '0;

   // Zero-latency return path; pmem_resp outside a SERVE state is dropped.
   assign a_resp  = (state == SERVE_A) && pmem_resp;
   assign b_resp  = (state == SERVE_B) && pmem_resp;
   assign a_rdata = pmem_rdata;
   assign b_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios then random traffic, checked
// each cycle against a transaction-level model (who is being served, with
// which captured request) and a line-granular memory model.
module tb_cache_arbiter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         a_read, b_read, b_write, a_resp, b_resp;
   logic [15:0]  a_addr, b_addr, pmem_addr;
   logic [127:0] a_rdata, b_rdata, b_wdata, pmem_wdata, pmem_rdata;
   logic         pmem_read, pmem_write, pmem_resp;

   cache_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a_read     (a_read),
      .a_addr     (a_addr),
      .a_resp     (a_resp),
      .a_rdata    (a_rdata),
      .b_read     (b_read),
      .b_write    (b_write),
      .b_addr     (b_addr),
      .b_wdata    (b_wdata),
      .b_resp     (b_resp),
      .b_rdata    (b_rdata),
      .pmem_read  (pmem_read),
      .pmem_write (pmem_write),
      .pmem_addr  (pmem_addr),
      .pmem_wdata (pmem_wdata),
      .pmem_resp  (pmem_resp),
      .pmem_rdata (pmem_rdata)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // model: m_srv = -1 none, 0 serving A, 1 serving B
   int           m_srv = -1;
   int           m_last = 0;
   bit           m_wr;
   logic [15:0]  m_addr;
   logic [127:0] m_wdata;
   int           m_cnt, m_lat;
   int           lat_cfg = 1;   // 0: random 1..3
   int           spur = 0;      // idle pmem_resp: 0 never, 1 random, 2 always
   bit           done_a, done_b;
   logic [127:0] mem [logic [15:0]];

   function automatic logic [127:0] mem_rd(input logic [15:0] a);
      if (mem.exists(a))
         return mem[a];
      return {8{a}};
   endfunction

   function automatic logic [127:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_srv  = -1;
      m_last = 0;
   endtask

   // One clock cycle: drive pmem, check outputs mid-low-phase, advance model.
   task automatic step();
      logic [127:0] rd_exp;
      int w;
      done_a = 0;
      done_b = 0;
      if (m_srv >= 0) begin
         m_cnt++;
         pmem_resp = (m_cnt >= m_lat);
      end else begin
         pmem_resp = (spur == 2) || (spur == 1 && $urandom_range(0, 5) == 0);
      end
      rd_exp = mem_rd(m_addr);
      pmem_rdata = (m_srv >= 0 && pmem_resp && !m_wr) ? rd_exp : rand_line();
      #2;
      chk("pmem_read",  128'(pmem_read),  128'(m_srv >= 0 && !m_wr));
      chk("pmem_write", 128'(pmem_write), 128'(m_srv >= 0 && m_wr));
      if (m_srv >= 0) begin
         chk("pmem_addr",  128'(pmem_addr), 128'(m_addr));
         chk("pmem_wdata", pmem_wdata, m_wr ? m_wdata : 128'd0);
      end
      chk("a_resp", 128'(a_resp), 128'(m_srv == 0 && pmem_resp));
      chk("b_resp", 128'(b_resp), 128'(m_srv == 1 && pmem_resp));
      if (m_srv == 0 && pmem_resp)
         chk("a_rdata", a_rdata, rd_exp);
      if (m_srv == 1 && pmem_resp && !m_wr)
         chk("b_rdata", b_rdata, rd_exp);
      @(posedge clk);
      if (m_srv >= 0) begin
         if (pmem_resp) begin
            if (m_wr)
               mem[m_addr] = m_wdata;
            done_a = (m_srv == 0);
            done_b = (m_srv == 1);
            m_srv  = -1;
         end
      end else begin
         if (a_read && (b_read || b_write))
            w = 1 - m_last;
         else if (a_read)
            w = 0;
         else if (b_read || b_write)
            w = 1;
         else
            w = -1;
         if (w == 0) begin
            m_wr = 0; m_addr = a_addr; m_wdata = '0;
         end else if (w == 1) begin
            m_wr = b_write; m_addr = b_addr; m_wdata = b_write ? b_wdata : '0;
         end
         if (w >= 0) begin
            m_srv  = w;
            m_last = w;
            m_cnt  = 0;
            m_lat  = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 3));
         end
      end
      @(negedge clk);
      if (done_a)
         a_read = 0;
      if (done_b) begin
         b_read  = 0;
         b_write = 0;
      end
   endtask

   initial begin
      int a_gap, b_gap;
      a_gap = 0;
      b_gap = 0;
      // reset state with busy-looking inputs
      rst_n = 0; a_read = 1; a_addr = 16'h1111; b_read = 0; b_write = 1;
      b_addr = 16'h2222; b_wdata = '1; pmem_resp = 1; pmem_rdata = '1;
      #3;
      chk("rst_pmem_read",  128'(pmem_read),  128'd0);
      chk("rst_pmem_write", 128'(pmem_write), 128'd0);
      chk("rst_pmem_addr",  128'(pmem_addr),  128'd0);
      chk("rst_pmem_wdata", pmem_wdata, 128'd0);
      chk("rst_a_resp", 128'(a_resp), 128'd0);
      chk("rst_b_resp", 128'(b_resp), 128'd0);
      a_read = 0; b_write = 0; pmem_resp = 0;
      @(negedge clk);
      rst_n = 1;
      model_reset();

      // single A read, 3-cycle memory
      mem[16'h1230] = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
      lat_cfg = 3; a_read = 1; a_addr = 16'h1230;
      repeat (6) step();

      // single B write, 1-cycle memory
      lat_cfg = 1; b_write = 1; b_addr = 16'h4000;
      b_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
      repeat (4) step();
      // read it back through A
      a_read = 1; a_addr = 16'h4000;
      repeat (3) step();

      // contention straight after reset: B first, then strict alternation
      rst_n = 0; #1; @(negedge clk); rst_n = 1; model_reset();
      lat_cfg = 2;
      a_read = 1; a_addr = 16'h1000; b_read = 1; b_addr = 16'h2000;
      for (int i = 0; i < 18; i++) begin
         step();
         if (!a_read) begin a_read = 1; a_addr = a_addr + 16'h10; end
         if (!b_read) begin b_read = 1; b_addr = b_addr + 16'h10; end
      end
      repeat (8) step();

      // B drops and changes its address mid-service
      lat_cfg = 3; b_read = 1; b_addr = 16'h5550;
      step();
      b_read = 0; b_addr = 16'h7770;
      repeat (4) step();

      // spurious pmem_resp while idle, then a normal grant
      spur = 2;
      repeat (3) step();
      spur = 0; lat_cfg = 1; a_read = 1; a_addr = 16'h3330;
      repeat (3) step();

      // reset during SERVE_A before pmem_resp
      lat_cfg = 5; a_read = 1; a_addr = 16'h6660;
      repeat (2) step();
      pmem_resp = 1; rst_n = 0;
      #1;
      chk("abort_pmem_read", 128'(pmem_read), 128'd0);
      chk("abort_pmem_addr", 128'(pmem_addr), 128'd0);
      chk("abort_a_resp",    128'(a_resp),    128'd0);
      a_read = 0; pmem_resp = 0;
      @(negedge clk);
      rst_n = 1; model_reset();
      repeat (4) step();

      // random traffic
      spur = 1; lat_cfg = 0;
      for (int c = 0; c < 600; c++) begin
         step();
         if (done_a) a_gap = $urandom_range(0, 2);
         if (done_b) b_gap = $urandom_range(0, 2);
         if (!a_read) begin
            if (a_gap == 0) begin
               a_read = 1; a_addr = 16'($urandom_range(0, 7) << 4);
            end else a_gap--;
         end
         if (!b_read && !b_write) begin
            if (b_gap == 0) begin
               b_addr  = 16'($urandom_range(0, 7) << 4);
               b_write = $urandom_range(0, 1) == 1;
               b_read  = !b_write || ($urandom_range(0, 7) == 0);
               b_wdata = rand_line();
            end else b_gap--;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
